// File: rtl/tape_recorder_if.sv
// Byte-write port from the tape recorder into the shared tape buffer.
interface tape_recorder_if;
    logic        wr_en;
    logic        wr;
    logic [24:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;

    modport master (input wr_en, input wr_ack, output wr, output wr_addr, output wr_data);
    modport slave  (output wr_en, output wr_ack, input wr, input wr_addr, input wr_data);
endinterface

// File: rtl/tape_recorder.sv
// CSW1 tape recorder: samples mic_in at RATE, run-length encodes edge
// intervals and streams header + RLE bytes into the tape buffer.
module tape_recorder #(
    parameter int unsigned CLOCK      = 3500000,
    parameter int unsigned RATE       = 44100,
    parameter logic [24:0] MAX_SIZE   = 25'h1FFFFFF,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce,
    input  logic            rec_en,
    input  logic            mic_in,
    tape_recorder_if.master wbus,
    output logic            busy,
    output logic            done,
    output logic [24:0]     rec_size,
    output logic            overflow,
    output logic            full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0]  RATE16 = 16'(RATE);
    localparam logic [175:0] MAGIC  = "Compressed Square Wave";

    typedef enum logic [2:0] {IDLE, WAITPOL, HDR, REC, FLUSH} state_t;
    state_t state, state_nxt;

    logic        rec_en_d, rise, fall, start, finish, active, tick, run_tick;
    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        pol, last;
    logic [31:0] run, pend_run;
    logic        pend_vld, final_req, stop_req;
    logic [2:0]  emit_idx;
    logic        emit_short, emit_push, hdr_push, push, latch_tick, latch_final;
    logic [7:0]  emit_byte, push_data;
    logic [5:0]  hdr_idx;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        f_empty, f_full;
    logic        wr;
    logic [24:0] wr_addr;
    logic [7:0]  wr_data;

    assign wbus.wr      = wr;
    assign wbus.wr_addr = wr_addr;
    assign wbus.wr_data = wr_data;

    function automatic logic [7:0] hdr_byte(input logic [4:0] idx, input logic p);
        logic [7:0] b;
        b = 8'h00;
        if (idx < 5'd22) b = 8'(MAGIC >> (8 * (21 - int'(idx))));
        else begin
            case (idx)
                5'd22:               b = 8'h1A;
                5'd23, 5'd24, 5'd27: b = 8'h01;
                5'd25:               b = RATE16[7:0];
                5'd26:               b = RATE16[15:8];
                5'd28:               b = {7'b0, p};
                default:             b = 8'h00;
            endcase
        end
        return b;
    endfunction

    assign rise     = rec_en & ~rec_en_d;
    assign fall     = ~rec_en & rec_en_d;
    assign active   = (state == WAITPOL) || (state == HDR) || (state == REC);
    assign acc_sum  = {1'b0, acc} + 33'(RATE);
    assign tick     = active && ce && (acc_sum >= 33'(CLOCK));
    // Runs are counted from the first tick onward, header still in flight or not.
    assign run_tick = tick && ((state == HDR) || (state == REC));

    assign f_empty    = (wptr == rptr);
    assign f_full     = ((wptr - rptr) == (AW + 1)'(FIFO_DEPTH));
    assign hdr_push   = (state == HDR) && !hdr_idx[5] && !f_full && !full;
    assign emit_short = (pend_run[31:8] == 24'd0);
    assign emit_push  = pend_vld && hdr_idx[5] && !f_full && !full;
    assign push       = hdr_push || emit_push;
    assign push_data  = hdr_push ? hdr_byte(hdr_idx[4:0], pol) : emit_byte;
    assign latch_tick  = run_tick && (mic_in != last);
    assign latch_final = (state == FLUSH) && final_req && !pend_vld && !full;

    // Current byte of the pending run: short form or 0x00 + 32-bit little-endian.
    always_comb begin
        emit_byte = 8'h00;
        if (emit_short) emit_byte = pend_run[7:0];
        else begin
            case (emit_idx)
                3'd1:    emit_byte = pend_run[7:0];
                3'd2:    emit_byte = pend_run[15:8];
                3'd3:    emit_byte = pend_run[23:16];
                3'd4:    emit_byte = pend_run[31:24];
                default: emit_byte = 8'h00;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; capacity exhaustion short-circuits straight to FLUSH.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = WAITPOL;
            WAITPOL: if (fall) state_nxt = FLUSH;
                     else if (tick) state_nxt = HDR;
            HDR:     if (full) state_nxt = FLUSH;
                     else if (hdr_push && hdr_idx[4:0] == 5'd31)
                         state_nxt = (stop_req || fall) ? FLUSH : REC;
            REC:     if (full || fall) state_nxt = FLUSH;
            FLUSH:   if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM strobes: start of a recording and completion of the flush.
    always_comb begin
        start  = 1'b0;
        finish = 1'b0;
        if (state == IDLE && rise) start = 1'b1;
        if (state == FLUSH && !wr && (full || (f_empty && !pend_vld && !final_req)))
            finish = 1'b1;
    end

    // Edge detector on rec_en and the fractional sample-rate accumulator.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rec_en_d <= 1'b0;
            acc      <= '0;
        end else begin
            rec_en_d <= rec_en;
            if (start) acc <= '0;
            else if (active && ce) acc <= tick ? 32'(acc_sum - 33'(CLOCK)) : acc_sum[31:0];
        end
    end

    // Run-length tracking of the sampled level.
    always_ff @(posedge clk_sys) begin
        if (reset || start) begin
            pol  <= 1'b0;
            last <= 1'b0;
            run  <= '0;
        end else if (state == WAITPOL && tick && !fall) begin
            pol  <= mic_in;
            last <= mic_in;
            run  <= 32'd1;
        end else if (run_tick) begin
            if (mic_in != last) begin
                run  <= 32'd1;
                last <= mic_in;
            end else if (run != '1) run <= run + 32'd1;
        end
    end

    // Header index and deferred stop request while the header is still queuing.
    always_ff @(posedge clk_sys) begin
        if (reset || start) begin
            hdr_idx  <= '0;
            stop_req <= 1'b0;
        end else begin
            if (hdr_push) hdr_idx <= hdr_idx + 6'd1;
            if (state == HDR && fall) stop_req <= 1'b1;
        end
    end

    // Pending-run register and emitter; a run arriving while occupied is lost.
    always_ff @(posedge clk_sys) begin
        if (reset || start) begin
            pend_run  <= '0;
            pend_vld  <= 1'b0;
            emit_idx  <= '0;
            final_req <= 1'b0;
            overflow  <= 1'b0;
        end else if (full) begin
            pend_vld  <= 1'b0;
            emit_idx  <= '0;
            final_req <= 1'b0;
        end else begin
            if (state == REC && fall) final_req <= 1'b1;
            if (emit_push) begin
                if (emit_short || emit_idx == 3'd4) begin
                    pend_vld <= 1'b0;
                    emit_idx <= '0;
                end else emit_idx <= emit_idx + 3'd1;
            end
            if (latch_tick) begin
                if (pend_vld) overflow <= 1'b1;
                else begin
                    pend_run <= run;
                    pend_vld <= 1'b1;
                end
            end else if (latch_final) begin
                pend_run  <= run;
                pend_vld  <= 1'b1;
                final_req <= 1'b0;
            end
        end
    end

    // FIFO storage (no reset needed; pointers define validity).
    always_ff @(posedge clk_sys) begin
        if (push && !f_full) mem[wptr[AW-1:0]] <= push_data;
    end

    // FIFO pointers and the request/acknowledge write port.
    always_ff @(posedge clk_sys) begin
        if (reset || start) begin
            wptr    <= '0;
            rptr    <= '0;
            wr      <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            full    <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (wr && wbus.wr_ack) begin
                wr      <= 1'b0;
                rptr    <= rptr + 1'b1;
                wr_addr <= wr_addr + 25'd1;
                if (wr_addr + 25'd1 == MAX_SIZE) begin
                    full <= 1'b1;
                    wptr <= '0;
                    rptr <= '0;
                end
            end else if (!wr && wbus.wr_en && !f_empty && !full) begin
                wr      <= 1'b1;
                wr_data <= mem[rptr[AW-1:0]];
            end
        end
    end

    // Status outputs visible to the host.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rec_size <= '0;
        end else begin
            done <= finish;
            if (start) begin
                busy     <= 1'b1;
                rec_size <= '0;
            end else if (finish) begin
                busy     <= 1'b0;
                rec_size <= wr_addr;
            end
        end
    end
endmodule

// File: tb/tb_tape_recorder.sv
// Randomized-level bench for tape_recorder with a run-list reference model.
module tb_tape_recorder;
    localparam int CLK_HZ = 88200;
    localparam int RATE   = 44100;
    localparam int MAXB   = 40;
    localparam int DEPTH  = 8;

    logic        clk_sys = 1'b1;
    logic        reset   = 1'b1;
    logic        ce      = 1'b0;
    logic        rec_en  = 1'b0;
    logic        mic_in  = 1'b0;
    logic        busy, done, overflow, full;
    logic [24:0] rec_size;

    tape_recorder_if wbus();

    tape_recorder #(.CLOCK(CLK_HZ), .RATE(RATE), .MAX_SIZE(25'(MAXB)), .FIFO_DEPTH(DEPTH)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce),
        .rec_en  (rec_en),
        .mic_in  (mic_in),
        .wbus    (wbus),
        .busy    (busy),
        .done    (done),
        .rec_size(rec_size),
        .overflow(overflow),
        .full    (full)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // buffer-side responder: ack one cycle after each request, record bytes
    bit         ack_on = 1'b0;
    bit         bp_win = 1'b0;
    int         wr_blk = 0;
    int         done_cnt = 0;
    bit         hit_max = 1'b0;
    logic [7:0] cap_q[$];
    int         addr_q[$];

    always @(negedge clk_sys) begin
        if (done) done_cnt++;
        if (bp_win && wbus.wr) wr_blk++;
        if (wbus.wr && wbus.wr_addr >= 25'(MAXB)) hit_max = 1'b1;
        if (ack_on && wbus.wr && !wbus.wr_ack) begin
            cap_q.push_back(wbus.wr_data);
            addr_q.push_back(int'(wbus.wr_addr));
            wbus.wr_ack = 1'b1;
        end else wbus.wr_ack = 1'b0;
    end

    // reference model: tick rule applied to issued ce pulses, runs as a list
    string      magic = "Compressed Square Wave";
    int         m_acc, m_run, m_ticks;
    bit         m_started, m_pol, m_last;
    int         m_runs[$];
    logic [7:0] exp_q[$];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic ce_pulse();
        ce = 1'b1;
        cyc(1);
        ce = 1'b0;
        m_acc += RATE;
        if (m_acc >= CLK_HZ) begin
            m_acc -= CLK_HZ;
            m_ticks++;
            if (!m_started) begin
                m_started = 1'b1;
                m_pol = mic_in;
                m_last = mic_in;
                m_run = 1;
            end else if (mic_in == m_last) m_run++;
            else begin
                m_runs.push_back(m_run);
                m_run = 1;
                m_last = mic_in;
            end
        end
        cyc(5);
    endtask

    task automatic ticks(input logic lvl, input int n);
        int target;
        mic_in = lvl;
        target = m_ticks + n;
        while (m_ticks < target) ce_pulse();
    endtask

    task automatic start_rec();
        cap_q.delete();
        addr_q.delete();
        m_runs.delete();
        m_acc = 0; m_run = 0; m_ticks = 0; m_started = 1'b0;
        done_cnt = 0; hit_max = 1'b0;
        rec_en = 1'b1;
        cyc(3);
        chk("busy_on", 32'(busy), 1);
    endtask

    task automatic stop_rec(input bit final_run);
        rec_en = 1'b0;
        if (final_run && m_started) m_runs.push_back(m_run);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            cyc(1);
            n++;
        end
        chk("done_seen", 32'(done_cnt > 0), 1);
        cyc(4);
        chk("done_once", 32'(done_cnt), 1);
        chk("busy_off", 32'(busy), 0);
    endtask

    task automatic build_exp(input bit pol);
        exp_q.delete();
        for (int i = 0; i < 22; i++) exp_q.push_back(8'(magic.getc(i)));
        exp_q.push_back(8'h1A); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        exp_q.push_back(8'(RATE)); exp_q.push_back(8'(RATE >> 8));
        exp_q.push_back(8'h01); exp_q.push_back({7'b0, pol});
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        foreach (m_runs[k]) begin
            int r;
            r = m_runs[k];
            if (r >= 1 && r <= 255) exp_q.push_back(8'(r));
            else begin
                exp_q.push_back(8'h00);
                for (int s = 0; s < 4; s++) exp_q.push_back(8'(r >> (8 * s)));
            end
        end
        while (exp_q.size() > MAXB) void'(exp_q.pop_back());
    endtask

    task automatic compare(input string name);
        chk({name, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        chk({name, "_rec_size"}, 32'(rec_size), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
            chk($sformatf("%s_addr%0d", name, i), 32'(addr_q[i]), 32'(i));
        end
    endtask

    task automatic header_test(input string name);
        logic lvl;
        lvl = 1'($urandom_range(0, 1));
        start_rec();
        ticks(lvl, 10);
        stop_rec(1'b1);
        wait_done();
        build_exp(m_pol);
        compare(name);
        chk({name, "_ovf"}, 32'(overflow), 0);
        chk({name, "_full"}, 32'(full), 0);
    endtask

    initial begin
        int n;
        logic lvl;
        wbus.wr_en = 1'b0;
        cyc(3);
        chk("rst_wr", 32'(wbus.wr), 0);
        chk("rst_addr", 32'(wbus.wr_addr), 0);
        chk("rst_data", 32'(wbus.wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_size", 32'(rec_size), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_full", 32'(full), 0);
        reset = 1'b0;
        ack_on = 1'b1;
        wbus.wr_en = 1'b1;
        cyc(2);

        header_test("hdr");

        // short and long runs
        lvl = 1'($urandom_range(0, 1));
        start_rec();
        ticks(lvl, 100); ticks(~lvl, 300); ticks(lvl, 5);
        stop_rec(1'b1);
        wait_done();
        build_exp(m_pol);
        compare("runs");

        // 255/256 boundary
        lvl = 1'($urandom_range(0, 1));
        start_rec();
        ticks(lvl, 255); ticks(~lvl, 256); ticks(lvl, 1);
        stop_rec(1'b1);
        wait_done();
        build_exp(m_pol);
        compare("bound");

        // backpressure: header stalls, second edge finds pending occupied
        wbus.wr_en = 1'b0;
        wr_blk = 0;
        start_rec();
        bp_win = 1'b1;
        for (int i = 0; i < 8; i++) ticks(1'(~i[0]), 1);
        chk("bp_ovf", 32'(overflow), 1);
        chk("bp_no_wr", 32'(wr_blk), 0);
        chk("bp_none_cap", 32'(cap_q.size()), 0);
        stop_rec(1'b0);
        cyc(3);
        bp_win = 1'b0;
        wbus.wr_en = 1'b1;
        wait_done();
        m_runs.delete();
        m_runs.push_back(1);
        build_exp(1'b1);
        compare("bp");
        chk("bp_ovf_sticky", 32'(overflow), 1);

        // capacity: MAX_SIZE reached mid-recording
        lvl = 1'($urandom_range(0, 1));
        start_rec();
        ticks(lvl, 10);
        for (int i = 0; i < 20; i++) ticks(1'(lvl ^ ~i[0]), 1);
        stop_rec(1'b0);
        wait_done();
        build_exp(m_pol);
        compare("cap");
        chk("cap_full", 32'(full), 1);
        chk("cap_no_addr_max", 32'(hit_max), 0);
        chk("cap_ovf", 32'(overflow), 0);

        // reset while a request is outstanding
        ack_on = 1'b0;
        start_rec();
        ticks(1'b1, 1);
        n = 0;
        while (!wbus.wr && n < 200) begin
            cyc(1);
            n++;
        end
        chk("mid_wr_seen", 32'(wbus.wr), 1);
        reset = 1'b1;
        rec_en = 1'b0;
        cyc(1);
        chk("mid_wr_drop", 32'(wbus.wr), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_addr", 32'(wbus.wr_addr), 0);
        reset = 1'b0;
        ack_on = 1'b1;
        cyc(2);
        header_test("restart");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
